ifu_fetch_buf: RTL and testbench

- Parametrised successor to the single-shot instruction fetch unit.
- Accepts fetch PCs from the PC stage and issues AXI-lite-style read requests (AR/R) to instruction SRAM, with up to DEPTH requests in flight.
- Buffers returned instructions, each with its PC, in an in-order FIFO feeding the IDU over a valid/ready handshake.
- Supports a flush/redirect that drops buffered and in-flight instructions.

---
 rtl/ifu_fetch_buf.sv | 169 ++++++++++++++++
 tb/tb_ifu_fetch_buf.sv | 352 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ifu_fetch_buf.sv
// ifu_fetch_buf -- pipelined instruction fetch unit with an in-order buffer.
//
// Accepts fetch PCs, issues AR/R reads to instruction SRAM with up to DEPTH
// reads in flight, and buffers returned instructions (with their PC) in an
// in-order FIFO that feeds the IDU over valid/ready. A flush drops everything
// buffered and every read still in flight.
//
// Optional feature: define IFU_ACCESS_FAULT_EN to report a non-OKAY rresp
// on inst_fault; otherwise rresp is ignored and inst_fault is always 0.
//
// Ports:
//   clk, rst                  clock (rising edge), async active-low reset
//   pc_valid/pc_ready/pc      fetch PC handshake from the PC stage
//   flush                     discard buffered and in-flight fetches
//   IFU_SRAM_araddr/arvalid,
//   SRAM_IFU_arready          read request channel
//   SRAM_IFU_rvalid/rdata/rresp,
//   IFU_SRAM_rready           read data channel
//   valid/ready               instruction handshake to the IDU
//   inst_wire/inst_pc/inst_fault  head entry of the instruction FIFO
module ifu_fetch_buf #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pc_valid,
  output logic              pc_ready,
  input  logic [ADDR_W-1:0] pc,
  input  logic              flush,
  output logic [ADDR_W-1:0] IFU_SRAM_araddr,
  output logic              IFU_SRAM_arvalid,
  input  logic              SRAM_IFU_arready,
  input  logic              SRAM_IFU_rvalid,
  output logic              IFU_SRAM_rready,
  input  logic [DATA_W-1:0] SRAM_IFU_rdata,
  input  logic [1:0]        SRAM_IFU_rresp,
  output logic              valid,
  input  logic              ready,
  output logic [DATA_W-1:0] inst_wire,
  output logic [ADDR_W-1:0] inst_pc,
  output logic              inst_fault
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW:0] DEPTH_C = (CW+1)'(DEPTH);

  typedef struct packed {
    logic [DATA_W-1:0] inst;
    logic [ADDR_W-1:0] pc;
    logic              fault;
  } entry_t;

  entry_t            fifo_q [DEPTH];
  logic [ADDR_W-1:0] pcq_q  [DEPTH];

  logic [PW-1:0]     wptr_q, wptr_d, rptr_q, rptr_d;
  logic [PW-1:0]     pq_wptr_q, pq_wptr_d, pq_rptr_q, pq_rptr_d;
  logic [CW-1:0]     count_q, count_d, out_q, out_d, drop_q, drop_d;
  logic              arvalid_q, arvalid_d;
  logic [ADDR_W-1:0] araddr_q, araddr_d;
  logic              doomed_q, doomed_d;
  logic              live_q;

  logic              ar_hs, r_beat, drop_beat, push_w, pop_w, pq_push, pc_acc;
  logic              beat_fault;
  logic [CW:0]       credit_sum;

`ifdef IFU_ACCESS_FAULT_EN
  assign beat_fault = (SRAM_IFU_rresp != 2'b00);
`else
  logic unused_rresp;
  assign unused_rresp = ^SRAM_IFU_rresp;
  assign beat_fault   = 1'b0;
`endif

  // live_q doubles as rready: low in reset, high from the first clock after.
  assign ar_hs      = arvalid_q & SRAM_IFU_arready;
  assign r_beat     = SRAM_IFU_rvalid & live_q;
  assign drop_beat  = r_beat && (drop_q != '0);
  assign push_w     = r_beat && (drop_q == '0) && !flush;
  assign pop_w      = valid && ready && !flush;
  // A request flushed before its handshake still goes out but must not
  // claim a PC-queue slot; its response is dropped instead.
  assign pq_push    = ar_hs && !doomed_q && !flush;

  // Buffered entries plus reads in flight never exceed DEPTH, so every
  // response has a FIFO slot reserved for it.
  assign credit_sum = {1'b0, count_q} + {1'b0, out_q};
  assign pc_ready   = live_q && !flush && !arvalid_q && (credit_sum < DEPTH_C);
  assign pc_acc     = pc_valid && pc_ready;

  always_comb begin
    arvalid_d = arvalid_q;
    araddr_d  = araddr_q;
    if (ar_hs)  arvalid_d = 1'b0;
    if (pc_acc) begin
      arvalid_d = 1'b1;
      araddr_d  = pc;
    end

    out_d = out_q + CW'(ar_hs) - CW'(r_beat);

    doomed_d = doomed_q;
    if (ar_hs) doomed_d = 1'b0;
    if (flush && arvalid_q && !ar_hs) doomed_d = 1'b1;

    // On flush every read still outstanding after this edge is dropped.
    drop_d = drop_q + CW'(ar_hs && doomed_q) - CW'(drop_beat);
    if (flush) drop_d = out_d;

    count_d   = count_q + CW'(push_w) - CW'(pop_w);
    wptr_d    = wptr_q + PW'(push_w);
    rptr_d    = rptr_q + PW'(pop_w);
    pq_wptr_d = pq_wptr_q + PW'(pq_push);
    pq_rptr_d = pq_rptr_q + PW'(push_w);
    if (flush) begin
      count_d   = '0;
      wptr_d    = '0;
      rptr_d    = '0;
      pq_wptr_d = '0;
      pq_rptr_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      live_q    <= 1'b0;
      arvalid_q <= 1'b0;
      araddr_q  <= '0;
      doomed_q  <= 1'b0;
      out_q     <= '0;
      drop_q    <= '0;
      count_q   <= '0;
      wptr_q    <= '0;
      rptr_q    <= '0;
      pq_wptr_q <= '0;
      pq_rptr_q <= '0;
    end else begin
      live_q    <= 1'b1;
      arvalid_q <= arvalid_d;
      araddr_q  <= araddr_d;
      doomed_q  <= doomed_d;
      out_q     <= out_d;
      drop_q    <= drop_d;
      count_q   <= count_d;
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      pq_wptr_q <= pq_wptr_d;
      pq_rptr_q <= pq_rptr_d;
    end
  end

  // Storage needs no reset: outputs are masked while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push_w)  fifo_q[wptr_q]   <= '{inst: SRAM_IFU_rdata, pc: pcq_q[pq_rptr_q], fault: beat_fault};
    if (pq_push) pcq_q[pq_wptr_q] <= araddr_q;
  end

  assign valid            = (count_q != '0);
  assign inst_wire        = valid ? fifo_q[rptr_q].inst  : '0;
  assign inst_pc          = valid ? fifo_q[rptr_q].pc    : '0;
  assign inst_fault       = valid ? fifo_q[rptr_q].fault : 1'b0;
  assign IFU_SRAM_araddr  = araddr_q;
  assign IFU_SRAM_arvalid = arvalid_q;
  assign IFU_SRAM_rready  = live_q;

endmodule

// File: tb/tb_ifu_fetch_buf.sv
// Testbench for ifu_fetch_buf: SRAM model plus an output scoreboard.
// Inputs change 1 time unit after the rising edge; everything is sampled on
// the falling edge, where the flags describe what the next rising edge does.
module tb_ifu_fetch_buf;
  logic        clk = 1'b0;
  logic        rst;
  logic        pc_valid, pc_ready, flush;
  logic [31:0] pc;
  logic [31:0] araddr;
  logic        arvalid, arready, rvalid, rready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        valid, ready, inst_fault;
  logic [31:0] inst_wire, inst_pc;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int nfault = 0;
  logic        r_stall = 1'b0;
  logic        fault_on = 1'b0;
  logic [31:0] fault_pc = 32'h0;

  typedef struct {
    logic [31:0] data;
    logic [31:0] pc;
    logic        fault;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] rq[$];

  ifu_fetch_buf #(.ADDR_W(32), .DATA_W(32), .DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .pc_valid(pc_valid), .pc_ready(pc_ready), .pc(pc), .flush(flush),
    .IFU_SRAM_araddr(araddr), .IFU_SRAM_arvalid(arvalid), .SRAM_IFU_arready(arready),
    .SRAM_IFU_rvalid(rvalid), .IFU_SRAM_rready(rready), .SRAM_IFU_rdata(rdata),
    .SRAM_IFU_rresp(rresp),
    .valid(valid), .ready(ready), .inst_wire(inst_wire), .inst_pc(inst_pc),
    .inst_fault(inst_fault)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] data_of(input logic [31:0] a);
    return ((a ^ 32'h8000_0000) << 8) | 32'h0000_0413;
  endfunction

  function automatic logic exp_fault(input logic [31:0] a);
`ifdef IFU_ACCESS_FAULT_EN
    return fault_on && (a == fault_pc);
`else
    return 1'b0;
`endif
  endfunction

  // SRAM: answers each accepted read one cycle later, in order.
  always @(posedge clk) begin
    #2;
    if (rq.size() != 0 && !r_stall) begin
      rvalid = 1'b1;
      rdata  = data_of(rq[0]);
      rresp  = (fault_on && rq[0] == fault_pc) ? 2'd2 : 2'd0;
    end else begin
      rvalid = 1'b0;
      rdata  = 32'h0;
      rresp  = 2'd0;
    end
  end

  // Scoreboard and SRAM bookkeeping.
  always @(negedge clk) begin
    if (!rst) begin
      sb.delete();
      rq.delete();
    end else begin
      if (dut.push_w && dut.count_q == 3'd4) begin
        failures++;
        $display("FAIL fifo_overflow push into full FIFO at cycle %0d", cyc);
      end
      if (pc_valid && pc_ready) sb.push_back('{data_of(pc), pc, exp_fault(pc)});
      if (arvalid && arready) rq.push_back(araddr);
      if (rvalid && rready && rq.size() != 0) void'(rq.pop_front());
      if (flush) sb.delete();
      else if (valid && ready) begin
        checks++;
        if (inst_fault) nfault++;
        if (sb.size() == 0) begin
          failures++;
          $display("FAIL unexpected_output got pc=%h inst=%h, required no output", inst_pc, inst_wire);
        end else begin
          exp_t e;
          e = sb.pop_front();
          if (inst_wire !== e.data || inst_pc !== e.pc || inst_fault !== e.fault) begin
            failures++;
            $display("FAIL output got inst=%h pc=%h fault=%b, required inst=%h pc=%h fault=%b",
                     inst_wire, inst_pc, inst_fault, e.data, e.pc, e.fault);
          end
        end
      end
    end
  end

  task automatic send_pc(input logic [31:0] a);
    int  n = 0;
    logic ok;
    pc = a;
    pc_valid = 1'b1;
    do begin
      @(negedge clk);
      ok = pc_ready;
      @(posedge clk);
      #1;
      n++;
    end while (!ok && n < 50);
    pc_valid = 1'b0;
    if (!ok) begin
      checks++;
      failures++;
      $display("FAIL send_pc_timeout pc=%h never accepted, required pc_ready within 50 cycles", a);
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(sb.size() == 0 && rq.size() == 0 && !valid && !arvalid) && n < 200);
    checks++;
    if (n >= 200) begin
      failures++;
      $display("FAIL drain_timeout got %0d expected entries left, required 0", sb.size());
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; pc_valid = 1'b0; pc = 32'h0; flush = 1'b0;
    arready = 1'b1; ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({arvalid, araddr, rready, pc_ready, valid, inst_wire, inst_pc, inst_fault} !== '0) begin
      failures++;
      $display("FAIL reset_outputs got arvalid=%b araddr=%h rready=%b pc_ready=%b valid=%b inst=%h pc=%h fault=%b, required all 0",
               arvalid, araddr, rready, pc_ready, valid, inst_wire, inst_pc, inst_fault);
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (rready !== 1'b1) begin
      failures++;
      $display("FAIL rready_after_reset got %b, required 1", rready);
    end
  endtask

  task automatic test_single_fetch();
    ready = 1'b1; arready = 1'b1;
    pc = 32'h8000_0000; pc_valid = 1'b1;
    @(negedge clk);
    checks++;
    if (pc_ready !== 1'b1) begin
      failures++;
      $display("FAIL single_pc_ready got %b, required 1", pc_ready);
    end
    @(posedge clk); #1;
    pc_valid = 1'b0;
    checks++;
    if (arvalid !== 1'b1 || araddr !== 32'h8000_0000) begin
      failures++;
      $display("FAIL single_ar got arvalid=%b araddr=%h, required 1 80000000", arvalid, araddr);
    end
    @(posedge clk); #1;
    checks++;
    if (valid !== 1'b0) begin
      failures++;
      $display("FAIL single_early_valid got %b, required 0", valid);
    end
    @(posedge clk); #1;
    checks++;
    if (valid !== 1'b1 || inst_wire !== 32'h0000_0413 || inst_pc !== 32'h8000_0000) begin
      failures++;
      $display("FAIL single_head got valid=%b inst=%h pc=%h, required 1 00000413 80000000",
               valid, inst_wire, inst_pc);
    end
    wait_idle();
  endtask

  task automatic test_backpressure();
    logic [31:0] h;
    ready = 1'b0;
    for (int i = 0; i < 4; i++) send_pc(32'h8000_0000 + 32'(4 * i));
    repeat (3) @(posedge clk);
    #1;
    h = inst_wire;
    checks++;
    if (valid !== 1'b1 || inst_pc !== 32'h8000_0000 || h !== 32'h0000_0413) begin
      failures++;
      $display("FAIL bp_head got valid=%b pc=%h inst=%h, required 1 80000000 00000413", valid, inst_pc, h);
    end
    pc = 32'h8000_0010; pc_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (pc_ready !== 1'b0 || inst_wire !== h) begin
        failures++;
        $display("FAIL bp_full got pc_ready=%b inst=%h, required 0 %h", pc_ready, inst_wire, h);
      end
    end
    @(posedge clk); #1;
    pc_valid = 1'b0;
    ready = 1'b1;
    wait_idle();
  endtask

  task automatic test_ar_stall();
    ready = 1'b1; arready = 1'b0;
    send_pc(32'h8000_0100);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (arvalid !== 1'b1 || araddr !== 32'h8000_0100 || pc_ready !== 1'b0) begin
        failures++;
        $display("FAIL ar_stall got arvalid=%b araddr=%h pc_ready=%b, required 1 80000100 0",
                 arvalid, araddr, pc_ready);
      end
    end
    @(posedge clk); #1;
    arready = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (arvalid !== 1'b0) begin
      failures++;
      $display("FAIL ar_release got arvalid=%b, required 0", arvalid);
    end
    wait_idle();
  endtask

  task automatic test_flush();
    int n = 0;
    ready = 1'b0; r_stall = 1'b0;
    send_pc(32'h8000_0200);
    while (!valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    r_stall = 1'b1;
    send_pc(32'h8000_0204);
    send_pc(32'h8000_0208);
    @(posedge clk); #1;
    flush = 1'b1;
    @(negedge clk);
    checks++;
    if (pc_ready !== 1'b0 || valid !== 1'b1 || arvalid !== 1'b0) begin
      failures++;
      $display("FAIL flush_cycle got pc_ready=%b valid=%b arvalid=%b, required 0 1 0", pc_ready, valid, arvalid);
    end
    @(posedge clk); #1;
    flush = 1'b0;
    checks++;
    if (valid !== 1'b0 || inst_pc !== 32'h0) begin
      failures++;
      $display("FAIL flush_valid got valid=%b pc=%h, required 0 00000000", valid, inst_pc);
    end
    r_stall = 1'b0;
    ready = 1'b1;
    send_pc(32'h8000_1000);
    wait_idle();
  endtask

  task automatic test_async_reset();
    ready = 1'b0;
    send_pc(32'h8000_0300);
    send_pc(32'h8000_0304);
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if ({arvalid, araddr, rready, pc_ready, valid, inst_wire, inst_pc, inst_fault} !== '0) begin
      failures++;
      $display("FAIL async_reset got arvalid=%b araddr=%h rready=%b pc_ready=%b valid=%b inst=%h pc=%h, required all 0",
               arvalid, araddr, rready, pc_ready, valid, inst_wire, inst_pc);
    end
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    test_single_fetch();
  endtask

  task automatic test_fault();
    int base;
    fault_on = 1'b1; fault_pc = 32'h8000_2004; ready = 1'b1;
    base = nfault;
    for (int i = 0; i < 3; i++) send_pc(32'h8000_2000 + 32'(4 * i));
    wait_idle();
    checks++;
`ifdef IFU_ACCESS_FAULT_EN
    if (nfault - base !== 1) begin
      failures++;
      $display("FAIL fault_count got %0d, required 1", nfault - base);
    end
`else
    if (nfault - base !== 0) begin
      failures++;
      $display("FAIL fault_count got %0d, required 0", nfault - base);
    end
`endif
    fault_on = 1'b0;
  endtask

  task automatic test_back_to_back();
    int t_prev, t;
    ready = 1'b1;
    send_pc(32'h8000_3000);
    t_prev = cyc;
    for (int i = 1; i < 8; i++) begin
      send_pc(32'h8000_3000 + 32'(4 * i));
      t = cyc;
      checks++;
      if (t - t_prev != 2) begin
        failures++;
        $display("FAIL b2b_spacing got %0d cycles between accepts, required 2", t - t_prev);
      end
      t_prev = t;
    end
    wait_idle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_fetch();
    test_backpressure();
    test_ar_stall();
    test_flush();
    test_async_reset();
    test_fault();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
